// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {ARB, PEND_I, PEND_D} arb_state_t;
  typedef enum logic [1:0] {RTN_NONE, RTN_I, RTN_D} rtn_sel_t;
endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant, mask and stall decision for the shared memory port.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_BURST = 4
) (
  input  arb_state_t       state,
  input  logic [CNT_W-1:0] burst_cnt,
  input  logic             ireq,
  input  logic             dreq,
  output logic             grant_i,
  output logic             grant_d,
  output logic             stall,
  output arb_state_t       state_next,
  output logic [CNT_W-1:0] burst_cnt_next
);

  always_comb begin
    grant_i        = 1'b0;
    grant_d        = 1'b0;
    stall          = 1'b0;
    state_next     = ARB;
    burst_cnt_next = burst_cnt;
    case (state)
      ARB: begin
        if (ireq && dreq) begin
          stall = 1'b1;
          // MAX_D_BURST <= 7, so the increment below can never wrap.
          if (burst_cnt < CNT_W'(MAX_D_BURST)) begin
            grant_d        = 1'b1;
            state_next     = PEND_I;
            burst_cnt_next = burst_cnt + 1'b1;
          end else begin
            grant_i        = 1'b1;
            state_next     = PEND_D;
            burst_cnt_next = '0;
          end
        end else if (ireq) begin
          grant_i        = 1'b1;
          burst_cnt_next = '0;
        end else if (dreq) begin
          grant_d = 1'b1;
        end
      end
      // Second half of a conflict: the counter is left alone here.
      PEND_I:  grant_i = 1'b1;
      PEND_D:  grant_d = 1'b1;
      default: state_next = ARB;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data access,
// serialising conflicts with a one-cycle stall and steering read data back.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_oen,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] ir,
  input  logic              d_oen,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall,
  output logic              mem_oen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_reg, state_next;
  rtn_sel_t          rtn_sel_reg, rtn_sel_next;
  logic [CNT_W-1:0]  burst_cnt_reg, burst_cnt_next;
  logic [DATA_W-1:0] ir_q_reg, d_q_reg;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] wdata_hold_reg;
  logic              ireq, dreq, d_write, grant_i, grant_d;

  // Requests are ignored while reset is held so the SRAM stays idle.
  assign ireq    = ~i_oen & rst_n;
  assign d_write = ~d_wen;
  assign dreq    = (~d_oen | d_write) & rst_n;

  mem_arb_grant #(.MAX_D_BURST(MAX_D_BURST)) u_grant (
    .state          (state_reg),
    .burst_cnt      (burst_cnt_reg),
    .ireq           (ireq),
    .dreq           (dreq),
    .grant_i        (grant_i),
    .grant_d        (grant_d),
    .stall          (stall),
    .state_next     (state_next),
    .burst_cnt_next (burst_cnt_next)
  );

  always_comb begin
    mem_oen      = 1'b1;
    mem_wen      = 1'b1;
    mem_addr     = addr_hold_reg;
    mem_wdata    = wdata_hold_reg;
    rtn_sel_next = RTN_NONE;
    if (grant_i) begin
      mem_oen      = 1'b0;
      mem_addr     = i_addr;
      rtn_sel_next = RTN_I;
    end else if (grant_d) begin
      mem_addr = d_addr;
      // A write wins over a simultaneous read on the data port.
      if (d_write) begin
        mem_wen   = 1'b0;
        mem_wdata = d_wdata;
      end else begin
        mem_oen      = 1'b0;
        rtn_sel_next = RTN_D;
      end
    end
  end

  assign ir      = (rtn_sel_reg == RTN_I) ? mem_rdata : ir_q_reg;
  assign d_rdata = (rtn_sel_reg == RTN_D) ? mem_rdata : d_q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ARB;
      rtn_sel_reg    <= RTN_NONE;
      burst_cnt_reg  <= '0;
      ir_q_reg       <= '0;
      d_q_reg        <= '0;
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
    end else begin
      state_reg      <= state_next;
      rtn_sel_reg    <= rtn_sel_next;
      burst_cnt_reg  <= burst_cnt_next;
      ir_q_reg       <= ir;
      d_q_reg        <= d_rdata;
      addr_hold_reg  <= mem_addr;
      wdata_hold_reg <= mem_wdata;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, 2048×32 synchronous SRAM between two requesters: the pipeline's instruction-fetch port and its data port. On a same-cycle conflict it serialises the two accesses and raises `stall`, which freezes the pipeline. It routes returned read data back to the correct requester and holds each port's last read value between accesses. It sits between the pipeline core and the unified instruction/data memory.

## Interface
Parameters:
- `MAX_D_BURST`, default 4: number of consecutive conflicts data may win before instruction fetch is forced to win one. Legal range 1..7.

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `i_oen`  in  1: instruction read request, active-low.
- `i_addr`  in  11: instruction address.
- `ir`  out  32: instruction read data.
- `d_oen`  in  1: data read request, active-low.
- `d_wen`  in  1: data write request, active-low.
- `d_addr`  in  11: data address.
- `d_wdata`  in  32: data write value.
- `d_rdata`  out  32: data read data.
- `stall`  out  1: freezes the pipeline; requesters hold all inputs stable while it is 1.
- `mem_oen`  out  1: SRAM read enable, active-low.
- `mem_wen`  out  1: SRAM write enable, active-low.
- `mem_addr`  out  11: SRAM address.
- `mem_wdata`  out  32: SRAM write data.
- `mem_rdata`  in  32: SRAM read data, valid the cycle after the read command.

## Operation
Request definitions:
- I request: `ireq = ~i_oen`.
- D request: `dreq = ~d_oen | ~d_wen`.
- If `d_oen` and `d_wen` are both low, the write wins and the read is dropped.

FSM states are `ARB`, `PEND_I` and `PEND_D`. Reset state is `ARB`.
- **`ARB`**
  - Neither request: the SRAM is idle (`mem_oen = mem_wen = 1`).
  - Exactly one request: grant it; `stall = 0`.
  - Both requests with `burst_cnt < MAX_D_BURST`: grant D, `stall = 1`, next state `PEND_I`, increment `burst_cnt`.
  - Both requests with `burst_cnt == MAX_D_BURST`: grant I, `stall = 1`, next state `PEND_D`, clear `burst_cnt`.
- **`PEND_I`**: grant I unconditionally and mask D, which was already served. `stall = 0`. Next state `ARB`.
- **`PEND_D`**: grant D unconditionally and mask I. `stall = 0`. Next state `ARB`.
- Any cycle in which I is granted outside a conflict also clears `burst_cnt`. The counter saturates and never wraps.

Memory command is combinational from the grant:
- I grant: `mem_addr = i_addr`, `mem_oen = 0`.
- D read: `mem_addr = d_addr`, `mem_oen = 0`.
- D write: `mem_addr = d_addr`, `mem_wdata = d_wdata`, `mem_wen = 0`.
- When nothing is granted, `mem_addr` and `mem_wdata` hold their last values.

Read return path:
- A 2-bit `rtn_sel` register records, at each edge, which port was granted a read: NONE, I or D.
- `ir = (rtn_sel == I) ? mem_rdata : ir_q`.
- `d_rdata = (rtn_sel == D) ? mem_rdata : d_q`.
- `ir_q` and `d_q` capture `ir` and `d_rdata` on every edge, so each port holds its last read value indefinitely.

## Timing
- Reset values, applied asynchronously and immediately: state `ARB`, `burst_cnt = 0`, `rtn_sel = NONE`, `ir_q = d_q = 0`. Outputs: `ir = 0`, `d_rdata = 0`, `stall = 0`, `mem_oen = mem_wen = 1`, `mem_addr = 0`, `mem_wdata = 0`.
- Reset asserted mid-sequence (in `PEND_I`/`PEND_D`) discards the pending access; after release the requester re-issues it.
- Unconflicted read latency: request in cycle t, data on `ir`/`d_rdata` in cycle t+1.
- Conflict:
  - Winner is served in cycle t; `stall = 1` in cycle t only.
  - Loser is served in cycle t+1.
  - Winner's data appears in t+1, loser's data in t+2.
- A write completes at the edge ending its grant cycle and produces no return data.
- `stall` is combinational from the requests and FSM state. It is never 1 in `PEND_I`/`PEND_D`, so there are no back-to-back stalls from a single conflict.

## Structure
- A shared package `mem_arb_pkg` holds:
  - the state enum `{ARB, PEND_I, PEND_D}`;
  - the return-select enum `{RTN_NONE, RTN_I, RTN_D}`;
  - the constants `ADDR_W = 11` and `DATA_W = 32`.
- One sub-module is natural: `mem_arb_grant`. It contains the combinational grant, mask and stall logic, with inputs state, `burst_cnt`, `ireq` and `dreq`. The top level keeps the registers and the memory muxing.

## Test plan
1. Reset with requests active: `rst_n = 0` while `i_oen = 0` -> immediately `mem_oen = 1`, `stall = 0`, `ir = 0`; nothing is granted until release.
2. Lone fetch: `i_oen = 0`, `i_addr = 5`, SRAM[5] = 0xDEADBEEF -> `mem_addr = 5` in cycle t, `ir = 0xDEADBEEF` in t+1, `stall = 0`; `ir` holds after `i_oen` rises.
3. Conflict:
   - Stimulus: `i_addr = 3` read and `d_addr = 9` read in the same cycle.
   - Cycle t: `stall = 1`, `mem_addr = 9`.
   - Cycle t+1: `mem_addr = 3`, `d_rdata` = SRAM[9], `stall = 0`.
   - Cycle t+2: `ir` = SRAM[3].
4. Fairness: with `MAX_D_BURST = 4`, the fifth consecutive conflict grants I first (`mem_addr = i_addr` while `stall = 1`), then D in the next cycle; `burst_cnt` returns to 0.
5. Write conflict:
   - Stimulus: `d_wen = 0`, `d_addr = 7`, `d_wdata = 0x12345678`, conflicting with an I read.
   - Cycle t: SRAM[7] is written.
   - Cycle t+1: D is masked (no second write).
   - A later read of address 7 returns 0x12345678.
6. Illegal combination: `d_oen = d_wen = 0` -> write performed, no data return, `d_rdata` unchanged.
